afio_cfg_ctrl: RTL and testbench

//  Register-mapped configuration controller for the 32-pin alternate-function IO mux.
//  It holds the GPIO output data, direction, AFC, PM and PS registers, and synchronises pin readback.
//  It sequences every AFC change as a glitch-free handover: affected pins are parked as GPIO inputs,

---
 rtl/afio_cfg_ctrl.sv | 167 ++++++++++++++++
 tb/tb_afio_cfg_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/afio_cfg_ctrl.sv
// Register-mapped configuration controller for the 32-pin alternate-function IO mux.
// Sequences AFC changes as park -> settle -> switch -> drain so pins never glitch between functions.
module afio_cfg_ctrl #(
    parameter int SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    input  logic [31:0] pin_in,
    output logic [31:0] gpio_di,
    output logic [31:0] gpio_dir,
    output logic [31:0] gpio_afc,
    output logic [63:0] gpio_pm,
    output logic [63:0] gpio_ps,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_PARK, S_SWITCH, S_DRAIN} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] dir_q, dir_d;
    logic [31:0] afc_cur_q, afc_cur_d;
    logic [31:0] afc_new_q, afc_new_d;
    logic [31:0] park_q, park_d;
    logic [31:0] sync1_q, sync1_d;
    logic [31:0] sync2_q, sync2_d;
    logic [63:0] pm_q, pm_d;
    logic [63:0] ps_q, ps_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;

    logic        busy_w;
    logic        sw_w;
    logic        accept;
    logic [31:0] chg;

    assign busy_w = (state_q != S_IDLE);
    assign sw_w   = (state_q == S_SWITCH);
    // Writes wait for IDLE so no register moves underneath a handover.
    assign accept = bus_req & ~ready_q & (~bus_we | ~busy_w);
    assign chg    = bus_wdata ^ afc_cur_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        dir_d     = dir_q;
        afc_cur_d = afc_cur_q;
        afc_new_d = afc_new_q;
        park_d    = park_q;
        pm_d      = pm_q;
        ps_d      = ps_q;
        sync1_d   = pin_in;
        sync2_d   = sync1_q;
        ready_d   = accept;
        rdata_d   = '0;

        if (accept && !bus_we) begin
            case (bus_addr)
                4'd0:    rdata_d = data_q;
                4'd3:    rdata_d = dir_q;
                4'd4:    rdata_d = afc_cur_q;
                4'd5:    rdata_d = pm_q[31:0];
                4'd6:    rdata_d = pm_q[63:32];
                4'd7:    rdata_d = ps_q[31:0];
                4'd8:    rdata_d = ps_q[63:32];
                4'd9:    rdata_d = sync2_q;
                4'd10:   rdata_d = {31'd0, busy_w};
                default: rdata_d = '0;
            endcase
        end

        case (state_q)
            S_PARK: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SWITCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SWITCH: begin
                afc_cur_d = afc_new_q;
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                park_d  = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept && bus_we) begin
            case (bus_addr)
                4'd0: data_d = bus_wdata;
                4'd1: data_d = data_q | bus_wdata;
                4'd2: data_d = data_q & ~bus_wdata;
                4'd3: dir_d  = bus_wdata;
                4'd4: begin
                    if (chg != '0) begin
                        afc_new_d = bus_wdata;
                        park_d    = chg;
                        cnt_d     = 8'd1;
                        state_d   = S_PARK;
                    end
                end
                4'd5: pm_d[31:0]  = bus_wdata;
                4'd6: pm_d[63:32] = bus_wdata;
                4'd7: ps_d[31:0]  = bus_wdata;
                4'd8: ps_d[63:32] = bus_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            dir_q     <= '0;
            afc_cur_q <= '0;
            afc_new_q <= '0;
            park_q    <= '0;
            pm_q      <= '0;
            ps_q      <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            dir_q     <= dir_d;
            afc_cur_q <= afc_cur_d;
            afc_new_q <= afc_new_d;
            park_q    <= park_d;
            pm_q      <= pm_d;
            ps_q      <= ps_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
        end
    end

    // Parked pins are inputs with AF off, except during SWITCH where the new AF is shown.
    assign gpio_dir  = dir_q & ~park_q;
    assign gpio_afc  = (afc_cur_q & ~park_q) | (afc_new_q & park_q & {32{sw_w}});
    assign gpio_di   = data_q;
    assign gpio_pm   = pm_q;
    assign gpio_ps   = ps_q;
    assign busy      = busy_w;
    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;

endmodule

// File: tb/tb_afio_cfg_ctrl.sv
// Bench for afio_cfg_ctrl: directed scenarios plus random bus traffic against a cycle-timeline model.
module tb_afio_cfg_ctrl;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic [31:0] pin_in;
    logic [31:0] gpio_di;
    logic [31:0] gpio_dir;
    logic [31:0] gpio_afc;
    logic [63:0] gpio_pm;
    logic [63:0] gpio_ps;
    logic        busy;

    always #5 clk = ~clk;

    afio_cfg_ctrl #(.SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .pin_in(pin_in),
        .gpio_di(gpio_di), .gpio_dir(gpio_dir), .gpio_afc(gpio_afc),
        .gpio_pm(gpio_pm), .gpio_ps(gpio_ps), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: register contents plus a handover timeline counted in cycles since accept.
    logic [31:0] m_data, m_dir, m_afc, m_rdata;
    logic [63:0] m_pm, m_ps;
    logic        m_ready;
    int          ho_t;
    logic [31:0] ho_new, ho_chg;
    logic [31:0] pin_q[$];
    logic        mon_en = 1'b0;

    function automatic logic [31:0] m_read(input logic [3:0] a, input logic bsy, input logic [31:0] rb);
        case (a)
            4'd0:    return m_data;
            4'd3:    return m_dir;
            4'd4:    return m_afc;
            4'd5:    return m_pm[31:0];
            4'd6:    return m_pm[63:32];
            4'd7:    return m_ps[31:0];
            4'd8:    return m_ps[63:32];
            4'd9:    return rb;
            4'd10:   return {31'd0, bsy};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic        bsy;
        logic        acc;
        logic [31:0] rb;
        if (rst) begin
            m_data = '0; m_dir = '0; m_afc = '0; m_pm = '0; m_ps = '0;
            m_ready = 1'b0; m_rdata = '0; ho_t = 0; ho_new = '0; ho_chg = '0;
            pin_q = {};
            pin_q.push_back(32'd0);
            pin_q.push_back(32'd0);
        end else begin
            bsy = (ho_t != 0);
            acc = bus_req && !m_ready && (!bus_we || !bsy);
            rb  = pin_q[0];
            m_rdata = (acc && !bus_we) ? m_read(bus_addr, bsy, rb) : 32'd0;
            if (ho_t != 0) begin
                if (ho_t == S + 1) m_afc = ho_new;
                ho_t = (ho_t == S + 2) ? 0 : ho_t + 1;
            end
            if (acc && bus_we) begin
                case (bus_addr)
                    4'd0: m_data = bus_wdata;
                    4'd1: m_data = m_data | bus_wdata;
                    4'd2: m_data = m_data & ~bus_wdata;
                    4'd3: m_dir  = bus_wdata;
                    4'd4: if (bus_wdata != m_afc) begin
                        ho_new = bus_wdata;
                        ho_chg = bus_wdata ^ m_afc;
                        ho_t   = 1;
                    end
                    4'd5: m_pm[31:0]  = bus_wdata;
                    4'd6: m_pm[63:32] = bus_wdata;
                    4'd7: m_ps[31:0]  = bus_wdata;
                    4'd8: m_ps[63:32] = bus_wdata;
                    default: ;
                endcase
            end
            m_ready = acc;
            pin_q.push_back(pin_in);
            void'(pin_q.pop_front());
        end
    end

    always @(negedge clk) begin : monitor
        logic [31:0] park;
        logic [31:0] exp_afc;
        if (mon_en) begin
            park    = (ho_t != 0) ? ho_chg : 32'd0;
            exp_afc = m_afc & ~park;
            if (ho_t == S + 1) exp_afc = exp_afc | (ho_new & park);
            chk("m_ready", bus_ready, m_ready);
            chk("m_rdata", bus_rdata, m_rdata);
            chk("m_di", gpio_di, m_data);
            chk("m_dir", gpio_dir, m_dir & ~park);
            chk("m_afc", gpio_afc, exp_afc);
            chk("m_pm", gpio_pm, m_pm);
            chk("m_ps", gpio_ps, m_ps);
            chk("m_busy", busy, ho_t != 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // lat = edges from request to completion; 1 means accepted on the first edge.
    task automatic bus_xfer(input logic we, input logic [3:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int lat);
        if (bus_ready) tick(1);
        bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!bus_ready && lat < 100);
        if (!bus_ready) chk("bus_timeout", 64'd0, 64'd1);
        rd = bus_rdata;
        bus_req = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    logic [31:0] last_afc;

    initial begin
        rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; pin_in = '0;
        tick(2);
        mon_en = 1'b1;
        chk("rst_dir", gpio_dir, 32'd0);
        chk("rst_afc", gpio_afc, 32'd0);
        chk("rst_ready", bus_ready, 1'b0);
        rst = 1'b0;
        tick(1);

        bus_xfer(1'b1, 4'd0, 32'h0000_00F0, rd, lat); chk("lat_data", lat, 1);
        bus_xfer(1'b1, 4'd1, 32'h0000_0001, rd, lat); chk("lat_set", lat, 1);
        bus_xfer(1'b1, 4'd2, 32'h0000_0010, rd, lat); chk("lat_clr", lat, 1);
        chk("di_e1", gpio_di, 32'h0000_00E1);

        bus_xfer(1'b1, 4'd3, 32'hFFFF_FFFF, rd, lat);
        bus_xfer(1'b1, 4'd4, 32'h0000_0003, rd, lat);
        chk("ho_lat", lat, 1);
        for (int k = 0; k < S; k++) begin
            chk("park_dir", gpio_dir, 32'hFFFF_FFFC);
            chk("park_afc", gpio_afc, 32'd0);
            chk("park_busy", busy, 1'b1);
            tick(1);
        end
        chk("sw_afc", gpio_afc, 32'h0000_0003);
        chk("sw_dir", gpio_dir, 32'hFFFF_FFFC);
        tick(2);
        chk("done_dir", gpio_dir, 32'hFFFF_FFFF);
        chk("done_afc", gpio_afc, 32'h0000_0003);
        chk("done_busy", busy, 1'b0);

        bus_xfer(1'b1, 4'd4, 32'h0000_0003, rd, lat);
        chk("same_afc_lat", lat, 1);
        chk("same_afc_busy", busy, 1'b0);

        bus_xfer(1'b1, 4'd4, 32'h0000_000F, rd, lat);
        bus_xfer(1'b0, 4'd10, 32'd0, rd, lat);
        chk("status_busy", rd, 32'h1);
        bus_xfer(1'b1, 4'd3, 32'h1234_5678, rd, lat);
        chk("stall_lat", lat > 1, 1'b1);
        chk("stall_idle", busy, 1'b0);
        chk("stall_dir", gpio_dir, 32'h1234_5678);
        bus_xfer(1'b0, 4'd4, 32'd0, rd, lat);
        chk("afc_rb", rd, 32'h0000_000F);

        pin_in = 32'hA5A5_0000;
        tick(3);
        bus_xfer(1'b0, 4'd9, 32'd0, rd, lat);
        chk("pin_rb", rd, 32'hA5A5_0000);

        bus_xfer(1'b1, 4'd5, 32'h1111_1111, rd, lat);
        bus_xfer(1'b1, 4'd6, 32'h2222_2222, rd, lat);
        bus_xfer(1'b1, 4'd7, 32'h3333_3333, rd, lat);
        bus_xfer(1'b1, 4'd8, 32'h4444_4444, rd, lat);
        chk("pm", gpio_pm, 64'h2222_2222_1111_1111);
        chk("ps", gpio_ps, 64'h4444_4444_3333_3333);
        bus_xfer(1'b1, 4'd12, 32'hDEAD_BEEF, rd, lat);
        bus_xfer(1'b0, 4'd12, 32'd0, rd, lat);
        chk("unmapped_rd", rd, 32'd0);

        bus_xfer(1'b1, 4'd3, 32'hFFFF_FFFF, rd, lat);
        bus_xfer(1'b1, 4'd4, 32'h0000_00F0, rd, lat);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_afc", gpio_afc, 32'd0);
        chk("mid_rst_dir", gpio_dir, 32'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", bus_ready, 1'b0);
        rst = 1'b0;
        tick(1);

        last_afc = '0;
        for (int i = 0; i < 400; i++) begin
            logic        we;
            logic [3:0]  a;
            logic [31:0] d;
            we = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = $urandom;
            if (a == 4'd4 && we) begin
                if ($urandom_range(0, 2) == 0) d = last_afc;
                else d = last_afc ^ (32'h1 << $urandom_range(0, 31));
                last_afc = d;
            end
            pin_in = $urandom;
            bus_xfer(we, a, d, rd, lat);
            tick($urandom_range(0, 2));
        end
        tick(S + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
